// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-0 constant, branch/jump/MDU decode codes, controller states.
// Latency: none (declarations and a pure combinational helper).
// Backpressure: not applicable.
package pipe_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Primary opcodes for control-flow decode
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;

  // SPECIAL funct codes for jr and the HI/LO unit
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  // A source only depends on a destination when it is a real register ($0 is hardwired zero)
  function automatic logic src_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// HI/LO occupancy timer: loads MDU_LAT on an issued mult/div, counts down to idle.
// Latency: busy rises the cycle after load and stays high for MDU_LAT cycles.
// Backpressure: none itself; the parent stalls HI/LO users and new starts while busy.
module hazard_ctrl_mdu_timer #(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  // At least 3 bits, wider when the latency needs it
  localparam int CW = ($clog2(MDU_LAT + 1) < 3) ? 3 : $clog2(MDU_LAT + 1);

  logic [CW-1:0] count;

  // Load on issue, otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(MDU_LAT);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline (branches and jumps resolved in ID).
// Latency: hold/flush/bubble outputs are combinational in the same cycle; counters update at the next edge.
// Backpressure: a detected hazard freezes PC and IF/ID and bubbles ID/EX; redirects wait for a stall-free cycle.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_mdu_start,
  input  logic             id_uses_hilo,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output state_e           fsm_state
);

  logic lu, bex, bmem, mdu, stall, redirect;
  logic timer_busy;

  // Hazard terms; branches always compare both rs and rt in ID
  always_comb begin
    lu       = ex_mem_read & (src_match(id_rs, ex_rd) | (id_uses_rt & src_match(id_rt, ex_rd)));
    bex      = id_is_branch & ex_reg_write & (src_match(id_rs, ex_rd) | src_match(id_rt, ex_rd));
    bmem     = id_is_branch & mem_mem_read & (src_match(id_rs, mem_rd) | src_match(id_rt, mem_rd));
    mdu      = timer_busy & (id_uses_hilo | id_mdu_start);
    stall    = lu | bex | bmem | mdu;
    // Branch outcome is meaningless while its operands are still in flight
    redirect = ~stall & (jump | (id_is_branch & branch_taken));
  end

  // A start waiting on a busy unit issues on the first cycle the timer reads zero
  hazard_ctrl_mdu_timer #(.MDU_LAT(MDU_LAT)) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (id_mdu_start & ~stall),
    .busy  (timer_busy)
  );

  // Pipeline control; reset fills IF/ID with NOPs and releases every hold
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mdu_busy    = rst_n & timer_busy;
    if (!rst_n) begin
      ifid_flush = 1'b1;
    end else if (stall) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = redirect;
    end
  end

  // RUN/STALL tracker for accounting and debug visibility
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= RUN;
    end else begin
      case (fsm_state)
        RUN:     if (stall)  fsm_state <= STALL;
        STALL:   if (!stall) fsm_state <= RUN;
        default: fsm_state <= RUN;
      endcase
    end
  end

  // Saturating performance counters: stalled cycles and issued redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor compares.
// Latency: each vector is applied just after a posedge and checked at the following negedge.
// Backpressure: not applicable.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       mst;
    logic       hilo;
    logic       tkn;
    logic       jmp;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
  } in_t;

  typedef struct {
    int         cyc;
    int         tag;
    logic [4:0] outs;
    logic [3:0] sc;
    logic [3:0] fc;
    logic       st;
  } exp_t;

  // {pc_hold, ifid_hold, ifid_flush, idex_bubble, mdu_busy}
  localparam logic [4:0] O_NO  = 5'b00000;
  localparam logic [4:0] O_FL  = 5'b00100;
  localparam logic [4:0] O_STL = 5'b11010;
  localparam logic [4:0] O_BSY = 5'b00001;
  localparam logic [4:0] O_MST = 5'b11011;

  logic clk = 1'b0;
  in_t  cur;
  int   cyc = 0;
  int   tag = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;

  logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, mdu_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  state_e           fsm_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (cur.rst),
    .id_rs        (cur.rs),
    .id_rt        (cur.rt),
    .id_uses_rt   (cur.uses_rt),
    .id_is_branch (cur.br),
    .id_mdu_start (cur.mst),
    .id_uses_hilo (cur.hilo),
    .branch_taken (cur.tkn),
    .jump         (cur.jmp),
    .ex_mem_read  (cur.ex_mr),
    .ex_reg_write (cur.ex_rw),
    .ex_rd        (cur.ex_rd),
    .mem_mem_read (cur.mem_mr),
    .mem_rd       (cur.mem_rd),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .mdu_busy     (mdu_busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .fsm_state    (fsm_state)
  );

  // Monitor: pop every expectation issued for this cycle and compare mid-cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, mdu_busy} !== e.outs) begin
        errors++;
        $display("FAIL vec%0d outs got %b want %b", e.tag,
                 {pc_hold, ifid_hold, ifid_flush, idex_bubble, mdu_busy}, e.outs);
      end
      checks++;
      if ({stall_cnt, flush_cnt, fsm_state} !== {e.sc, e.fc, e.st}) begin
        errors++;
        $display("FAIL vec%0d cnt stall/flush/state got %0d/%0d/%0d want %0d/%0d/%0d", e.tag,
                 stall_cnt, flush_cnt, fsm_state, e.sc, e.fc, e.st);
      end
    end
  end

  task automatic vec(input in_t i, input logic [4:0] eo, input int esc, input int efc,
                     input state_e est);
    exp_t x;
    @(posedge clk);
    #1;
    cur   = i;
    x.cyc = cyc;
    x.tag = tag;
    x.outs = eo;
    x.sc  = 4'(esc);
    x.fc  = 4'(efc);
    x.st  = est;
    q.push_back(x);
    tag++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    in_t z;
    in_t i;
    z = '0;
    z.rst = 1'b1;
    cur = '0;

    // Reset state
    i = '0;                                                vec(i, O_FL, 0, 0, RUN);

    // Load-use on rs and rt, register-0 exclusion, rt ignored when unused
    i = z; i.ex_mr = 1; i.ex_rd = 8; i.rs = 8;             vec(i, O_STL, 0, 0, RUN);
    i = z; i.ex_mr = 1; i.ex_rd = 0; i.rs = 0;             vec(i, O_NO, 1, 0, STALL);
    i = z; i.ex_mr = 1; i.ex_rd = 5; i.rt = 5; i.uses_rt = 1; vec(i, O_STL, 1, 0, RUN);
    i = z; i.ex_mr = 1; i.ex_rd = 5; i.rt = 5;             vec(i, O_NO, 2, 0, STALL);

    // Taken branch, jump, untaken branch
    i = z; i.br = 1; i.tkn = 1; i.rs = 3; i.rt = 4;        vec(i, O_FL, 2, 0, RUN);
    i = z; i.jmp = 1;                                      vec(i, O_FL, 2, 1, RUN);
    i = z; i.br = 1; i.rs = 3; i.rt = 4;                   vec(i, O_NO, 2, 2, RUN);

    // Branch operands pending in MEM then EX; EX writer alone does not stall non-branches
    i = z; i.br = 1; i.tkn = 1; i.mem_mr = 1; i.mem_rd = 9; i.rt = 9; vec(i, O_STL, 2, 2, RUN);
    i = z; i.br = 1; i.tkn = 1; i.rt = 9;                  vec(i, O_FL, 3, 2, STALL);
    i = z; i.br = 1; i.tkn = 1; i.ex_rw = 1; i.ex_rd = 7; i.rs = 7; vec(i, O_STL, 3, 3, RUN);
    i = z; i.br = 1; i.ex_rw = 1; i.ex_rd = 0; i.rs = 0;   vec(i, O_NO, 4, 3, STALL);
    i = z; i.ex_rw = 1; i.ex_rd = 7; i.rs = 7;             vec(i, O_NO, 4, 3, RUN);

    // mult issues, mfhi waits out the occupancy window
    i = z; i.mst = 1;                                      vec(i, O_NO, 4, 3, RUN);
    i = z;                                                 vec(i, O_BSY, 4, 3, RUN);
    i = z; i.hilo = 1;                                     vec(i, O_MST, 4, 3, RUN);
    i = z; i.hilo = 1;                                     vec(i, O_MST, 5, 3, STALL);
    i = z; i.hilo = 1;                                     vec(i, O_MST, 6, 3, STALL);
    i = z; i.hilo = 1;                                     vec(i, O_NO, 7, 3, STALL);

    // Back-to-back starts: the second waits until the count reaches zero
    i = z; i.mst = 1;                                      vec(i, O_NO, 7, 3, RUN);
    i = z; i.mst = 1;                                      vec(i, O_MST, 7, 3, RUN);
    i = z; i.mst = 1;                                      vec(i, O_MST, 8, 3, STALL);
    i = z; i.mst = 1;                                      vec(i, O_MST, 9, 3, STALL);
    i = z; i.mst = 1;                                      vec(i, O_MST, 10, 3, STALL);
    i = z; i.mst = 1;                                      vec(i, O_NO, 11, 3, STALL);
    i = z;                                                 vec(i, O_BSY, 11, 3, RUN);
    i = z;                                                 vec(i, O_BSY, 11, 3, RUN);

    // Asynchronous reset between edges while the timer holds 2
    i = z; i.rst = 0;                                      vec(i, O_FL, 0, 0, RUN);
    i = z;                                                 vec(i, O_NO, 0, 0, RUN);
    i = z; i.ex_mr = 1; i.ex_rd = 8; i.rs = 8;             vec(i, O_STL, 0, 0, RUN);
    i = z; i.jmp = 1;                                      vec(i, O_FL, 1, 0, STALL);

    // Stall counter saturates at all-ones
    i = z; i.ex_mr = 1; i.ex_rd = 8; i.rs = 8;
    for (int k = 0; k < 20; k++) begin
      vec(i, O_STL, (k + 1 > 15) ? 15 : k + 1, 1, (k == 0) ? RUN : STALL);
    end
    i = z;                                                 vec(i, O_NO, 15, 1, STALL);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
